alsu_resp_checker: RTL and testbench

ALSU_RESP_CHECKER -- requirements
Module: alsu_resp_checker

---
 rtl/alsu_resp_checker_if.sv | 35 +++
 rtl/alsu_resp_checker.sv | 140 ++++++++++++++
 tb/tb_alsu_resp_checker.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alsu_resp_checker_if.sv
// ============================================================================
// Module      : alsu_resp_checker_if
// Description : Expectation/observation bundle between an ALSU stimulus source
//               and the response checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alsu_resp_checker_if;
    logic        clr;
    logic        exp_valid;
    logic        exp_ready;
    logic [5:0]  exp_out;
    logic        exp_invalid;
    logic [5:0]  dut_out;
    logic [15:0] dut_leds;
    logic        chk_valid;
    logic        mismatch;
    logic [15:0] pass_cnt;
    logic [15:0] fail_cnt;
    logic        err_sticky;
    logic [1:0]  state;

    modport master (
        output clr, exp_valid, exp_out, exp_invalid, dut_out, dut_leds,
        input  exp_ready, chk_valid, mismatch, pass_cnt, fail_cnt, err_sticky, state
    );

    modport slave (
        input  clr, exp_valid, exp_out, exp_invalid, dut_out, dut_leds,
        output exp_ready, chk_valid, mismatch, pass_cnt, fail_cnt, err_sticky, state
    );
endinterface

`default_nettype wire

// File: rtl/alsu_resp_checker.sv
// ============================================================================
// Module      : alsu_resp_checker
// Description : Delays each accepted ALSU expectation by LATENCY cycles and
//               scores it against the observed out/leds.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alsu_resp_checker #(
    parameter int unsigned LATENCY     = 2,
    parameter bit          HALT_ON_ERR = 1'b1
) (
    input  wire logic           clk,
    input  wire logic           rst,
    alsu_resp_checker_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_HALT = 2'b10
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_ready;
    logic                w_xfer;
    logic                w_chk;
    logic                w_chk_fail;
    logic                w_pipe_empty;

    logic [LATENCY-1:0]  r_pipe_vld;
    logic [LATENCY-1:0]  r_pipe_inv;
    logic [5:0]          r_pipe_out [LATENCY];

    logic [15:0]         r_leds_prev;
    logic [15:0]         r_pass_cnt;
    logic [15:0]         r_fail_cnt;
    logic                r_chk_valid;
    logic                r_mismatch;
    logic                r_err_sticky;

    assign w_xfer       = bus.exp_valid & w_ready;
    assign w_chk        = r_pipe_vld[LATENCY-1];
    assign w_pipe_empty = ~|r_pipe_vld;

    // Invalid-opcode responses must zero out and visibly move the leds.
    always_comb begin
        w_chk_fail = 1'b0;
        if (w_chk) begin
            if (r_pipe_inv[LATENCY-1])
                w_chk_fail = !((bus.dut_out == 6'd0) && (bus.dut_leds != r_leds_prev));
            else
                w_chk_fail = !((bus.dut_out == r_pipe_out[LATENCY-1]) && (bus.dut_leds == 16'h0000));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || bus.clr) begin
            r_pipe_vld <= '0;
        end else begin
            r_pipe_vld[0] <= w_xfer;
            for (int i = 1; i < LATENCY; i++)
                r_pipe_vld[i] <= r_pipe_vld[i-1];
        end
    end

    // Payload needs no reset: it is only consumed alongside a valid bit.
    always_ff @(posedge clk) begin
        r_pipe_out[0] <= bus.exp_out;
        r_pipe_inv[0] <= bus.exp_invalid;
        for (int i = 1; i < LATENCY; i++) begin
            r_pipe_out[i] <= r_pipe_out[i-1];
            r_pipe_inv[i] <= r_pipe_inv[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || bus.clr) begin
            r_leds_prev  <= 16'h0000;
            r_pass_cnt   <= 16'h0000;
            r_fail_cnt   <= 16'h0000;
            r_chk_valid  <= 1'b0;
            r_mismatch   <= 1'b0;
            r_err_sticky <= 1'b0;
        end else begin
            r_leds_prev <= bus.dut_leds;
            r_chk_valid <= w_chk;
            r_mismatch  <= w_chk_fail;
            if (w_chk && !w_chk_fail && (r_pass_cnt != 16'hFFFF))
                r_pass_cnt <= r_pass_cnt + 16'd1;
            if (w_chk_fail && (r_fail_cnt != 16'hFFFF))
                r_fail_cnt <= r_fail_cnt + 16'd1;
            if (w_chk_fail)
                r_err_sticky <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || bus.clr)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // A halting mismatch outranks the return to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (w_xfer)
                    w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_chk_fail && HALT_ON_ERR)
                    w_state_nxt = S_HALT;
                else if (w_pipe_empty && !w_xfer)
                    w_state_nxt = S_IDLE;
            end
            S_HALT: begin
                w_ready = 1'b0;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.exp_ready  = w_ready;
    assign bus.chk_valid  = r_chk_valid;
    assign bus.mismatch   = r_mismatch;
    assign bus.pass_cnt   = r_pass_cnt;
    assign bus.fail_cnt   = r_fail_cnt;
    assign bus.err_sticky = r_err_sticky;
    assign bus.state      = r_state;

endmodule

`default_nettype wire

// File: tb/tb_alsu_resp_checker.sv
// ============================================================================
// Module      : tb_alsu_resp_checker
// Description : Self-checking bench: vector table and corner sequences on a
//               halting LATENCY=2 checker, random scoring and saturation on a
//               non-halting LATENCY=3 checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alsu_resp_checker;

    localparam logic [1:0] C_IDLE = 2'b00;
    localparam logic [1:0] C_RUN  = 2'b01;
    localparam logic [1:0] C_HALT = 2'b10;

    logic clk;
    logic rst;

    alsu_resp_checker_if b0 ();
    alsu_resp_checker_if b1 ();

    alsu_resp_checker #(.LATENCY(2), .HALT_ON_ERR(1'b1)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    alsu_resp_checker #(.LATENCY(3), .HALT_ON_ERR(1'b0)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Inputs change and outputs are sampled 1 time unit after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [5:0]  eo;
        logic        ei;
        logic [15:0] lp;
        logic [5:0]  dout;
        logic [15:0] leds;
        logic        mis;
    } vec_t;

    typedef struct {
        int         due;
        logic [5:0] eo;
        logic       ei;
    } pend_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{6'b000100, 1'b0, 16'h0000, 6'b000100, 16'h0000, 1'b0};
        vecs[1] = '{6'b001010, 1'b0, 16'h0000, 6'b001011, 16'h0000, 1'b1};
        vecs[2] = '{6'b111111, 1'b0, 16'h0000, 6'b111111, 16'h0001, 1'b1};
        vecs[3] = '{6'b010101, 1'b1, 16'h0000, 6'b000000, 16'hFFFF, 1'b0};
        vecs[4] = '{6'b010101, 1'b1, 16'hFFFF, 6'b000000, 16'hFFFF, 1'b1};
        vecs[5] = '{6'b000000, 1'b1, 16'h0000, 6'b000001, 16'h0001, 1'b1};
        vecs[6] = '{6'b000000, 1'b0, 16'h0000, 6'b000000, 16'h0000, 1'b0};
        vecs[7] = '{6'b100001, 1'b1, 16'h1234, 6'b000000, 16'h1235, 1'b0};

        rst = 1'b0;
        b0.clr = 1'b0; b0.exp_valid = 1'b0; b0.exp_out = '0; b0.exp_invalid = 1'b0;
        b0.dut_out = '0; b0.dut_leds = '0;
        b1.clr = 1'b0; b1.exp_valid = 1'b0; b1.exp_out = '0; b1.exp_invalid = 1'b0;
        b1.dut_out = '0; b1.dut_leds = '0;
        #1;
        step(); step(); step();

        // ---------------- reset state
        rst = 1'b1;
        chk("rst_pass_cnt", 32'(b0.pass_cnt), 0);
        chk("rst_fail_cnt", 32'(b0.fail_cnt), 0);
        chk("rst_err", 32'(b0.err_sticky), 0);
        chk("rst_chk_valid", 32'(b0.chk_valid), 0);
        chk("rst_mismatch", 32'(b0.mismatch), 0);
        chk("rst_state", 32'(b0.state), 32'(C_IDLE));
        step();
        chk("rst_ready", 32'(b0.exp_ready), 1);

        // ---------------- single-transaction vector table
        for (int v = 0; v < 8; v++) begin
            b0.clr = 1'b1; b0.exp_valid = 1'b0; b0.dut_out = '0; b0.dut_leds = '0;
            step();
            b0.clr = 1'b0; b0.exp_valid = 1'b1;
            b0.exp_out = vecs[v].eo; b0.exp_invalid = vecs[v].ei;
            step();
            b0.exp_valid = 1'b0; b0.dut_leds = vecs[v].lp;
            step();
            b0.dut_out = vecs[v].dout; b0.dut_leds = vecs[v].leds;
            step();
            chk($sformatf("vec%0d_chk_valid", v), 32'(b0.chk_valid), 1);
            chk($sformatf("vec%0d_mismatch", v), 32'(b0.mismatch), 32'(vecs[v].mis));
            chk($sformatf("vec%0d_pass_cnt", v), 32'(b0.pass_cnt), vecs[v].mis ? 0 : 1);
            chk($sformatf("vec%0d_fail_cnt", v), 32'(b0.fail_cnt), vecs[v].mis ? 1 : 0);
            chk($sformatf("vec%0d_err", v), 32'(b0.err_sticky), 32'(vecs[v].mis));
            b0.dut_out = '0; b0.dut_leds = '0;
            step();
            chk($sformatf("vec%0d_pulse_end", v), 32'(b0.chk_valid), 0);
            chk($sformatf("vec%0d_state", v), 32'(b0.state), vecs[v].mis ? 32'(C_HALT) : 32'(C_IDLE));
            chk($sformatf("vec%0d_ready", v), 32'(b0.exp_ready), vecs[v].mis ? 0 : 1);
        end

        // ---------------- halt rejects new expectations, clr recovers
        b0.clr = 1'b1; b0.exp_valid = 1'b0; step();
        b0.clr = 1'b0; b0.exp_valid = 1'b1; b0.exp_out = 6'b001010; b0.exp_invalid = 1'b0; step();
        b0.exp_valid = 1'b0; step();
        b0.dut_out = 6'b001011; b0.dut_leds = '0; step();
        chk("halt_state", 32'(b0.state), 32'(C_HALT));
        b0.exp_valid = 1'b1; b0.exp_out = 6'b000111; b0.dut_out = 6'b000111;
        for (int k = 0; k < 4; k++) begin
            step();
            if (k > 0) chk($sformatf("halt_no_chk%0d", k), 32'(b0.chk_valid), 0);
        end
        chk("halt_fail_cnt", 32'(b0.fail_cnt), 1);
        chk("halt_pass_cnt", 32'(b0.pass_cnt), 0);
        b0.exp_valid = 1'b0; b0.clr = 1'b1; step();
        b0.clr = 1'b0;
        chk("clr_fail_cnt", 32'(b0.fail_cnt), 0);
        chk("clr_err", 32'(b0.err_sticky), 0);
        chk("clr_state", 32'(b0.state), 32'(C_IDLE));
        chk("clr_ready", 32'(b0.exp_ready), 1);

        // ---------------- in-flight entry still scored after halting
        b0.exp_valid = 1'b1; b0.exp_out = 6'd5; step();
        b0.exp_out = 6'd6; step();
        b0.exp_valid = 1'b0; b0.dut_out = 6'd9; step();
        chk("inflight_mis", 32'(b0.mismatch), 1);
        chk("inflight_halt", 32'(b0.state), 32'(C_HALT));
        b0.dut_out = 6'd6; step();
        chk("inflight_chk", 32'(b0.chk_valid), 1);
        chk("inflight_mis2", 32'(b0.mismatch), 0);
        chk("inflight_pass", 32'(b0.pass_cnt), 1);
        chk("inflight_fail", 32'(b0.fail_cnt), 1);

        // ---------------- clr on the comparing edge suppresses the check
        b0.clr = 1'b1; step();
        b0.clr = 1'b0; b0.exp_valid = 1'b1; b0.exp_out = 6'd3; step();
        b0.exp_valid = 1'b0; step();
        b0.dut_out = 6'd3; b0.clr = 1'b1; step();
        b0.clr = 1'b0;
        chk("clrchk_valid", 32'(b0.chk_valid), 0);
        chk("clrchk_pass", 32'(b0.pass_cnt), 0);
        step();
        chk("clrchk_valid2", 32'(b0.chk_valid), 0);

        // ---------------- five back-to-back transfers
        for (int k = 0; k < 7; k++) begin
            b0.exp_valid = (k < 5);
            b0.exp_out = 6'(k + 1);
            b0.dut_out = (k >= 2) ? 6'(k - 1) : 6'd0;
            b0.dut_leds = '0;
            step();
            if (k >= 2) begin
                chk($sformatf("b2b_chk%0d", k), 32'(b0.chk_valid), 1);
                chk($sformatf("b2b_mis%0d", k), 32'(b0.mismatch), 0);
            end
        end
        b0.exp_valid = 1'b0; step();
        chk("b2b_end_chk", 32'(b0.chk_valid), 0);
        chk("b2b_pass_cnt", 32'(b0.pass_cnt), 5);

        // ---------------- reset with two expectations in flight
        b0.clr = 1'b1; step();
        b0.clr = 1'b0; b0.exp_valid = 1'b1; b0.exp_out = 6'd10; step();
        b0.exp_out = 6'd11; step();
        b0.exp_valid = 1'b0; rst = 1'b0; step();
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            b0.dut_out = (k == 0) ? 6'd11 : 6'd0;
            step();
            chk($sformatf("rstmid_chk%0d", k), 32'(b0.chk_valid), 0);
        end
        chk("rstmid_pass", 32'(b0.pass_cnt), 0);
        chk("rstmid_fail", 32'(b0.fail_cnt), 0);
        chk("rstmid_state", 32'(b0.state), 32'(C_IDLE));

        // ---------------- random scoring against a due-cycle model (dut1)
        begin
            pend_t       q[$];
            pend_t       it;
            logic [15:0] m_prev, leds;
            logic [5:0]  dout;
            int          m_pass, m_fail;
            bit          m_err, has_chk, good, ok;
            m_prev = '0; m_pass = 0; m_fail = 0; m_err = 1'b0;
            b1.clr = 1'b1; b1.dut_leds = '0; step();
            b1.clr = 1'b0;
            for (int c = 0; c < 400; c++) begin
                has_chk = 1'b0;
                dout = 6'($urandom);
                leds = 16'($urandom);
                if (q.size() > 0 && q[0].due == c) begin
                    it = q.pop_front();
                    has_chk = 1'b1;
                    good = ($urandom_range(0, 2) != 0);
                    if (it.ei) begin
                        dout = good ? 6'd0 : (($urandom_range(0, 1) != 0) ? 6'($urandom_range(1, 63)) : 6'd0);
                        leds = (good || dout != 0) ? (m_prev ^ 16'($urandom_range(1, 65535))) : m_prev;
                    end else begin
                        dout = good ? it.eo : (it.eo ^ 6'($urandom_range(0, 63)));
                        leds = (good || dout != it.eo) ? 16'h0000 : 16'($urandom_range(1, 65535));
                    end
                end
                b1.dut_out = dout;
                b1.dut_leds = leds;
                b1.exp_valid = ($urandom_range(0, 3) != 0);
                b1.exp_out = 6'($urandom);
                b1.exp_invalid = ($urandom_range(0, 4) == 0);
                if (b1.exp_valid)
                    q.push_back('{c + 3, b1.exp_out, b1.exp_invalid});
                ok = 1'b0;
                if (has_chk) begin
                    if (it.ei) ok = (dout == 6'd0) && (leds != m_prev);
                    else       ok = (dout == it.eo) && (leds == 16'h0000);
                    if (ok) m_pass++;
                    else begin m_fail++; m_err = 1'b1; end
                end
                m_prev = leds;
                step();
                chk("rnd_chk_valid", 32'(b1.chk_valid), 32'(has_chk));
                chk("rnd_mismatch", 32'(b1.mismatch), 32'(has_chk && !ok));
                chk("rnd_pass_cnt", 32'(b1.pass_cnt), 32'(m_pass));
                chk("rnd_fail_cnt", 32'(b1.fail_cnt), 32'(m_fail));
                chk("rnd_err", 32'(b1.err_sticky), 32'(m_err));
                chk("rnd_ready", 32'(b1.exp_ready), 1);
            end
        end

        // ---------------- fail counter saturation without halting (dut1)
        b1.clr = 1'b1; b1.exp_valid = 1'b0; step();
        b1.clr = 1'b0;
        b1.exp_out = 6'd0; b1.exp_invalid = 1'b0; b1.dut_out = 6'd1; b1.dut_leds = '0;
        for (int k = 0; k < 65541; k++) begin
            b1.exp_valid = (k < 65537);
            step();
            if (k == 65536) chk("sat_fffe", 32'(b1.fail_cnt), 32'h0000FFFE);
            if (k == 65537) chk("sat_ffff", 32'(b1.fail_cnt), 32'h0000FFFF);
        end
        chk("sat_hold", 32'(b1.fail_cnt), 32'h0000FFFF);
        chk("sat_pass", 32'(b1.pass_cnt), 0);
        chk("sat_err", 32'(b1.err_sticky), 1);
        chk("sat_ready", 32'(b1.exp_ready), 1);
        chk("sat_state", 32'(b1.state), 32'(C_IDLE));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
